// File: rtl/bexkat1_mem_pkg.sv
// bexkat1 memory-stage shared types.
// Ops, access sizes, fault codes and LSU state.
package bexkat1_mem_pkg;

  typedef enum logic [2:0] {
    MOP_NONE, MOP_LOAD, MOP_STORE, MOP_PUSH,
    MOP_POP, MOP_JSR, MOP_RTS, MOP_EXC
  } mem_op_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [1:0] FLT_BUS     = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT = 2'd2;
  localparam logic [1:0] FLT_ALIGN   = 2'd3;

  function automatic logic is_write(mem_op_t op);
    return op inside {MOP_STORE, MOP_PUSH, MOP_JSR, MOP_EXC};
  endfunction

  // Only plain loads/stores carry a size; stack and control ops move words.
  function automatic mem_size_t eff_size(mem_op_t op, mem_size_t sz);
    return (op inside {MOP_LOAD, MOP_STORE}) ? sz : SZ_W;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for a DATA_W Wishbone bus.
// Byte 0 is the MSB lane; read side right-justifies and extends.
module mem_lane_align
  import bexkat1_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_size_t           size_i,
  input  logic [2:0]          addr_i,
  input  logic                sext_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                misalign_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(SEL_W);

  logic [IDX_W-1:0]  idx;
  logic [3:0]        nbytes;
  logic [3:0]        lsh;
  logic [6:0]        bsh;
  logic [SEL_W-1:0]  base_sel;
  logic [DATA_W-1:0] dmask;
  logic [DATA_W-1:0] rsh;
  logic              sign;

  assign idx = addr_i[IDX_W-1:0];

  always_comb begin
    nbytes     = 4'd1;
    base_sel   = '0;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_B: base_sel[0] = 1'b1;
      SZ_H: begin
        nbytes        = 4'd2;
        base_sel[1:0] = 2'b11;
        misalign_o    = addr_i[0];
      end
      SZ_W: begin
        nbytes        = 4'd4;
        base_sel[3:0] = 4'hf;
        misalign_o    = |addr_i[1:0];
      end
      SZ_D: begin
        nbytes     = 4'd8;
        base_sel   = '1;
        misalign_o = (DATA_W == 32) || (|addr_i);
      end
    endcase

    // Lane distance of the access from the LSB end of the bus.
    lsh = 4'(SEL_W) - 4'(idx) - nbytes;
    bsh = {lsh, 3'b000};

    dmask = '0;
    for (int i = 0; i < SEL_W; i++) begin
      dmask[i*8 +: 8] = {8{base_sel[i]}};
    end

    sel_o   = base_sel << lsh;
    wdata_o = (wdata_i & dmask) << bsh;
    rsh     = (rdata_i >> bsh) & dmask;

    sign = 1'b0;
    unique case (size_i)
      SZ_B: sign = rsh[7];
      SZ_H: sign = rsh[15];
      SZ_W: sign = rsh[31];
      SZ_D: sign = 1'b0;
    endcase

    rdata_o = (sext_i && sign) ? (rsh | ~dmask) : rsh;
  end

endmodule

// File: rtl/mem_lsu.sv
// bexkat1 memory stage: pipelined Wishbone master for loads,
// stores, stack ops and control transfers.
module mem_lsu
  import bexkat1_mem_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int SEL_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  output logic              stall_o,
  input  mem_op_t           op_i,
  input  mem_size_t         size_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [31:0]       pc_i,
  input  logic              pc_set_i,
  input  logic [1:0]        sp_write_i,
  output logic [DATA_W-1:0] result_o,
  output logic [31:0]       pc_o,
  output logic              pc_set_o,
  output logic [1:0]        sp_write_o,
  output logic              fault_o,
  output logic [1:0]        fault_code_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state;
  mem_op_t           op_q;
  mem_size_t         size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       tgt_q;
  logic [1:0]        spw_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              idle;
  logic              resp;
  logic              tmo_hit;
  mem_size_t         in_size;
  mem_size_t         al_size;
  logic [2:0]        al_addr;
  logic [DATA_W-1:0] al_wsrc;
  logic [SEL_W-1:0]  al_sel;
  logic [DATA_W-1:0] al_wd;
  logic [DATA_W-1:0] al_rd;
  logic              al_mis;

  assign idle    = state == S_IDLE;
  assign in_size = eff_size(op_i, size_i);
  assign al_size = idle ? in_size : size_q;
  assign al_addr = idle ? addr_i[2:0] : addr_q[2:0];
  assign al_wsrc = (op_i inside {MOP_JSR, MOP_EXC}) ? DATA_W'(pc_i)
                                                    : wdata_i;

  // Strobe accepted this cycle, so a response may land with it.
  assign resp    = (state == S_WAIT) || (state == S_REQ && !wb_stall_i);
  assign cnt_nxt = cnt + 1'b1;
  assign tmo_hit = (TIMEOUT > 0) && (cnt_nxt == CNT_W'(TIMEOUT));

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i    (al_size),
    .addr_i    (al_addr),
    .sext_i    (sext_q),
    .wdata_i   (al_wsrc),
    .rdata_i   (wb_dat_i),
    .sel_o     (al_sel),
    .wdata_o   (al_wd),
    .rdata_o   (al_rd),
    .misalign_o(al_mis)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      op_q         <= MOP_NONE;
      size_q       <= SZ_B;
      sext_q       <= 1'b0;
      addr_q       <= '0;
      tgt_q        <= '0;
      spw_q        <= '0;
      cnt          <= '0;
      stall_o      <= 1'b0;
      result_o     <= '0;
      pc_o         <= '0;
      pc_set_o     <= 1'b0;
      sp_write_o   <= '0;
      fault_o      <= 1'b0;
      fault_code_o <= '0;
      fault_addr_o <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
    end else begin
      fault_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!stall_i) begin
            if (op_i == MOP_NONE) begin
              result_o   <= result_i;
              pc_o       <= pc_i;
              pc_set_o   <= pc_set_i;
              sp_write_o <= sp_write_i;
            end else if (al_mis) begin
              fault_o      <= 1'b1;
              fault_code_o <= FLT_ALIGN;
              fault_addr_o <= addr_i;
              pc_set_o     <= 1'b0;
              sp_write_o   <= '0;
            end else begin
              op_q       <= op_i;
              size_q     <= in_size;
              sext_q     <= sext_i;
              addr_q     <= addr_i;
              tgt_q      <= result_i[31:0];
              spw_q      <= sp_write_i;
              wb_cyc_o   <= 1'b1;
              wb_stb_o   <= 1'b1;
              wb_we_o    <= is_write(op_i);
              wb_adr_o   <= addr_i;
              wb_sel_o   <= al_sel;
              wb_dat_o   <= is_write(op_i) ? al_wd : '0;
              pc_set_o   <= 1'b0;
              sp_write_o <= '0;
              stall_o    <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (resp && wb_err_i) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            fault_o      <= 1'b1;
            fault_code_o <= FLT_BUS;
            fault_addr_o <= addr_q;
            pc_set_o     <= 1'b0;
            sp_write_o   <= '0;
            stall_o      <= 1'b0;
            state        <= S_IDLE;
          end else if (resp && wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            pc_set_o   <= 1'b0;
            sp_write_o <= spw_q;
            stall_o    <= 1'b0;
            state      <= S_IDLE;
            unique case (op_q)
              MOP_LOAD, MOP_POP: result_o <= al_rd;
              MOP_RTS: begin
                pc_o     <= al_rd[31:0];
                pc_set_o <= 1'b1;
              end
              MOP_JSR: begin
                pc_o     <= tgt_q;
                pc_set_o <= 1'b1;
              end
              MOP_EXC: begin
                pc_o       <= tgt_q;
                pc_set_o   <= 1'b1;
                sp_write_o <= 2'h3;
              end
              default: ;
            endcase
          end else if (state == S_REQ) begin
            if (!wb_stall_i) begin
              wb_stb_o <= 1'b0;
              cnt      <= '0;
              state    <= S_WAIT;
            end
          end else if (tmo_hit) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            fault_o      <= 1'b1;
            fault_code_o <= FLT_TIMEOUT;
            fault_addr_o <= addr_q;
            pc_set_o     <= 1'b0;
            sp_write_o   <= '0;
            stall_o      <= 1'b0;
            cnt          <= cnt_nxt;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          stall_o <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Parametrised memory-stage load/store unit for the bexkat1 pipeline, sitting between execute and writeback. It takes a pre-decoded memory operation rather than the raw IR and runs it as a pipelined Wishbone master. It supports configurable bus width, byte/half/word/dword lanes, optional sign extension, bus-error and timeout handling, and misalignment faults. It forwards result/pc/sp-write controls to writeback and stalls upstream while a bus cycle is outstanding.

Parameters:
DATA_W, 32, bus data width; legal values 32 or 64.
ADDR_W, 32, address width.
TIMEOUT, 255, cycles to wait for ack/err after strobe acceptance; 0 disables the timeout.
SEL_W, DATA_W/8, byte-select width (derived, not overridable).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
stall_i  in  1  downstream/upstream pipeline stall
stall_o  out  1  stage busy; high whenever state != S_IDLE
op_i  in  mem_op_t  operation; MOP_NONE = pass-through
size_i  in  mem_size_t  access size
sext_i  in  1  sign-extend loads
addr_i  in  ADDR_W  effective address (ALU result or sp)
wdata_i  in  DATA_W  store/push data
result_i  in  DATA_W  pass-through result
pc_i  in  32  pc of this instruction
pc_set_i  in  1  pass-through pc_set
sp_write_i  in  2  pass-through sp_write
result_o  out  DATA_W  result to writeback
pc_o  out  32  pc / branch target
pc_set_o  out  1  redirect fetch
sp_write_o  out  2  sp write control
fault_o  out  1  one-cycle fault pulse
fault_code_o  out  2  FLT_BUS / FLT_TIMEOUT / FLT_ALIGN
fault_addr_o  out  ADDR_W  faulting address, held until next fault
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls
wb_adr_o  out  ADDR_W  address
wb_sel_o  out  SEL_W  byte lanes
wb_dat_o  out  DATA_W  write data
wb_dat_i  in  DATA_W  read data
wb_ack_i, wb_err_i, wb_stall_i  in  1  Wishbone responses

Behaviour:
- Reset (rst_i, asynchronous, active-high; clock clk_i): all outputs 0, state S_IDLE, timeout counter 0.
- All outputs are registered.
- Pass-through: when idle and op_i=MOP_NONE, result/pc/pc_set/sp_write follow their inputs with 1-cycle latency. When stall_i or stall_o is high, these outputs hold.
- Issue: in S_IDLE with op_i!=MOP_NONE and !stall_i:
  - latch the op;
  - drive cyc=stb=1, adr=addr_i, and we for STORE/PUSH/JSR/EXC;
  - go to S_REQ.
  - Write data: PUSH/STORE use wdata_i; JSR/EXC use pc_i.
- Lanes (big-endian, byte 0 = MSB lane; index = addr low log2(SEL_W) bits):
  - byte: one lane;
  - half: two lanes;
  - word: 4 lanes; the full bus when DATA_W=32;
  - dword: legal only when DATA_W=64.
  - Store data is replicated or shifted into the selected lanes; unselected lanes are 0.
- Alignment check happens before issue. A half on an odd address, a word not 4-aligned, a dword not 8-aligned, or a dword when DATA_W=32:
  - no bus cycle is started;
  - fault_o pulses with FLT_ALIGN and fault_addr_o=addr_i;
  - the stage stays idle.
- S_REQ: hold stb until !wb_stall_i, then drop stb, clear the counter and go to S_WAIT. An ack or err arriving in that same cycle is handled as in S_WAIT.
- S_WAIT: the counter increments each cycle. Priority is err > ack > timeout.
  - ack:
    - drop cyc/we and return to S_IDLE;
    - LOAD/POP: result_o = selected lanes right-justified, zero- or sign-extended per sext_i (POP is always a full word);
    - RTS: pc_o=data, pc_set_o=1;
    - JSR/EXC: pc_o=addr target (result_i latched), pc_set_o=1; EXC also sets sp_write_o=2'h3;
    - PUSH: sp_write_o passes through.
  - err: drop cyc and pulse fault_o with FLT_BUS. result/pc are not updated; pc_set_o=0.
  - Counter reaching TIMEOUT (when TIMEOUT>0): drop cyc/stb and pulse FLT_TIMEOUT.
- After any completion, the stage returns to S_IDLE and stall_o drops in the same registered cycle. Back-to-back ops therefore need ≥1 idle cycle.
- Reset mid-cycle drops cyc/stb immediately; no fault is reported.
- A late ack after a timeout is ignored.

Decomposition:
- Package bexkat1_mem_pkg holds:
  - mem_op_t {MOP_NONE, MOP_LOAD, MOP_STORE, MOP_PUSH, MOP_POP, MOP_JSR, MOP_RTS, MOP_EXC};
  - mem_size_t {SZ_B, SZ_H, SZ_W, SZ_D};
  - fault codes;
  - state_t {S_IDLE, S_REQ, S_WAIT}.
- One sub-module, mem_lane_align, is purely combinational (size, addr, wdata → sel, aligned wdata, misalign flag; plus the read-side extract/extend). It is reused by ifetch widening later.

Test Plan:
- DATA_W=32, LOAD SZ_B at 0x1003, sext=1, slave returns 0x000000F0 with ack after 2 cycles -> sel=0001, result_o=0xFFFFFFF0, stall_o high for 3 cycles.
- STORE SZ_H at 0x2002, wdata=0x1234ABCD, wb_stall_i high 3 cycles -> stb held 4 cycles, sel=0011, dat_o=0x0000ABCD, we=1.
- DATA_W=64, LOAD SZ_D at 0x4008, data 0x0123456789ABCDEF -> sel=FF, result_o equals the data; then SZ_D at 0x4004 -> FLT_ALIGN, fault_addr_o=0x4004, cyc never asserted.
- JSR with addr=0x7FFC, pc_i=0x100, result_i=0x2000 -> write 0x100 to 0x7FFC, then pc_o=0x2000, pc_set_o=1 for one cycle.
- LOAD where the slave asserts err with ack in the same cycle -> FLT_BUS, result_o unchanged, cyc dropped next edge.
- TIMEOUT=4, slave silent -> cyc drops after 4 wait cycles, FLT_TIMEOUT; a later ack is ignored; assert rst_i mid-wait -> cyc=0 asynchronously.
